// File: rtl/enc_stream_loader.sv
// Byte-stream front end for a block-cipher core: collects 8 key bytes and 16 plaintext
// bytes, runs the core under a watchdog, then streams the 16-byte cipher result out.
module enc_stream_loader #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [7:0]   out_data,
    input  logic         out_ready,
    output logic         enc_start,
    input  logic         enc_end,
    output logic [0:63]  enc_key,
    output logic [0:127] enc_plain,
    input  logic [0:127] enc_cipher,
    output logic         timeout_err
);

    typedef enum logic [1:0] {LOAD, RUN, DRAIN} state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t         state_q, state_d;
    logic [5:0]     byte_cnt_q, byte_cnt_d;
    logic [15:0]    wait_cnt_q, wait_cnt_d;
    logic [3:0]     out_cnt_q, out_cnt_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [7:0]     out_data_q, out_data_d;
    logic           enc_start_q, enc_start_d;
    logic [0:63]    key_q, key_d;
    logic [0:127]   plain_q, plain_d;
    logic [0:127]   cipher_q, cipher_d;
    logic           timeout_err_q, timeout_err_d;

    logic           in_xfer, out_xfer;
    logic [3:0]     plain_byte, out_cnt_nxt;

    assign in_xfer     = in_valid & in_ready_q;
    assign out_xfer    = out_valid_q & out_ready;
    // Byte counts 8..23 map onto plaintext bytes 0..15 by wrapping the low nibble.
    assign plain_byte  = byte_cnt_q[3:0] - 4'd8;
    assign out_cnt_nxt = out_cnt_q + 4'd1;

    // NOTE: combinational next-state logic uses blocking '=' with every target defaulted
    // first so no latch is inferred; the register block below uses only '<='.
    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        out_cnt_d     = out_cnt_q;
        in_ready_d    = in_ready_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        enc_start_d   = enc_start_q;
        key_d         = key_q;
        plain_d       = plain_q;
        cipher_d      = cipher_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            LOAD: begin
                in_ready_d = 1'b1;
                if (in_xfer) begin
                    timeout_err_d = 1'b0;
                    if (byte_cnt_q < 6'd8)
                        key_d[{byte_cnt_q[2:0], 3'b000} +: 8] = in_data;
                    else
                        plain_d[{plain_byte, 3'b000} +: 8] = in_data;
                    if (byte_cnt_q == 6'd23) begin
                        byte_cnt_d  = 6'd0;
                        wait_cnt_d  = 16'd0;
                        in_ready_d  = 1'b0;
                        enc_start_d = 1'b1;
                        state_d     = RUN;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 6'd1;
                    end
                end
            end
            RUN: begin
                // A core finishing on the watchdog's final cycle still wins.
                if (enc_end) begin
                    cipher_d    = enc_cipher;
                    out_data_d  = enc_cipher[0:7];
                    out_valid_d = 1'b1;
                    out_cnt_d   = 4'd0;
                    wait_cnt_d  = 16'd0;
                    enc_start_d = 1'b0;
                    state_d     = DRAIN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    wait_cnt_d    = 16'd0;
                    enc_start_d   = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = LOAD;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            DRAIN: begin
                if (out_xfer) begin
                    if (out_cnt_q == 4'd15) begin
                        out_valid_d = 1'b0;
                        out_cnt_d   = 4'd0;
                        state_d     = LOAD;
                    end else begin
                        out_cnt_d  = out_cnt_nxt;
                        out_data_d = cipher_q[{out_cnt_nxt, 3'b000} +: 8];
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // NOTE: the wide key/plain/cipher registers are plain flops rather than a memory,
    // so they are reset to zero alongside the control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= LOAD;
            byte_cnt_q    <= '0;
            wait_cnt_q    <= '0;
            out_cnt_q     <= '0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            enc_start_q   <= 1'b0;
            key_q         <= '0;
            plain_q       <= '0;
            cipher_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            out_cnt_q     <= out_cnt_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            enc_start_q   <= enc_start_d;
            key_q         <= key_d;
            plain_q       <= plain_d;
            cipher_q      <= cipher_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign enc_start   = enc_start_q;
    assign enc_key     = key_q;
    assign enc_plain   = plain_q;
    assign timeout_err = timeout_err_q;

endmodule
